// File: rtl/uart_pkg.sv
// Shared constants for the uart_tx_dev peripheral: register map, bit positions, FSM encoding.
package uart_pkg;

   localparam logic [1:0] ADDR_TXDATA = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_DIV    = 2'd3;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;

   localparam int CTRL_IEN  = 0;
   localparam int CTRL_TXEN = 1;
   localparam int CTRL_ODD  = 2;

   localparam int FRAME_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic       o_full,
   output logic       o_empty,
   output logic [7:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_push_ok;
   logic        w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop_ok  = i_pop && !o_empty;
   // A push into a full FIFO is still accepted when the head leaves on the same edge.
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_head    = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter (bridge DEV2). Define UART_TX_PARITY_EN for a
// parity bit selected by CTRL[2] (1 = odd, 0 = even).
module uart_tx_dev
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_RESET  = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DataI,
   output logic [31:0] DataO,
   output logic        IRQ,
   output logic        TxD
);

   tx_state_t   r_state, w_state_nx;
   logic [15:0] r_cnt, w_cnt_nx;
   logic [15:0] r_bitlen, w_bitlen_nx;
   logic [2:0]  r_idx, w_idx_nx;
   logic [7:0]  r_shift, w_shift_nx;
   logic        r_txd, w_txd_nx;
   logic [15:0] r_div;
   logic        r_ien, r_txen, r_ovf, r_irq;
`ifdef UART_TX_PARITY_EN
   logic        r_odd;
   logic        r_par, w_par_nx;
`endif

   logic        w_push, w_pop, w_load, w_bit_end, w_busy;
   logic        w_full, w_empty;
   logic [7:0]  w_head;
   logic        w_unused_data;

   assign w_push        = WE && (Addr == ADDR_TXDATA);
   assign w_busy        = (r_state != ST_IDLE);
   assign w_bit_end     = (r_cnt == 16'd0);
   assign w_unused_data = ^DataI[31:16];

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_data  (DataI[7:0]),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_bitlen_nx = r_bitlen;
      w_idx_nx    = r_idx;
      w_shift_nx  = r_shift;
      w_load      = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nx    = r_par;
`endif
      unique case (r_state)
         ST_IDLE: w_load = r_txen && !w_empty;
         ST_START: begin
            if (w_bit_end) begin
               w_state_nx = ST_DATA;
               w_cnt_nx   = r_bitlen - 16'd1;
               w_idx_nx   = 3'd0;
            end else w_cnt_nx = r_cnt - 16'd1;
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_cnt_nx = r_bitlen - 16'd1;
               if (r_idx == 3'(FRAME_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nx = ST_PARITY;
`else
                  w_state_nx = ST_STOP;
`endif
               end else begin
                  w_shift_nx = {1'b0, r_shift[7:1]};
                  w_idx_nx   = r_idx + 3'd1;
               end
            end else w_cnt_nx = r_cnt - 16'd1;
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               w_state_nx = ST_STOP;
               w_cnt_nx   = r_bitlen - 16'd1;
            end else w_cnt_nx = r_cnt - 16'd1;
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (r_txen && !w_empty) w_load = 1'b1;
               else                    w_state_nx = ST_IDLE;
            end else w_cnt_nx = r_cnt - 16'd1;
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // Frame start: the bit length is captured here so DIV writes only affect later frames.
      if (w_load) begin
         w_state_nx  = ST_START;
         w_shift_nx  = w_head;
         w_bitlen_nx = r_div;
         w_cnt_nx    = r_div - 16'd1;
`ifdef UART_TX_PARITY_EN
         w_par_nx    = (^w_head) ^ r_odd;
`endif
      end
      w_pop = w_load;

      unique case (w_state_nx)
         ST_START:  w_txd_nx = 1'b0;
         ST_DATA:   w_txd_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_txd_nx = w_par_nx;
`endif
         default:   w_txd_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_bitlen <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_bitlen <= w_bitlen_nx;
         r_idx    <= w_idx_nx;
         r_shift  <= w_shift_nx;
         r_txd    <= w_txd_nx;
`ifdef UART_TX_PARITY_EN
         r_par    <= w_par_nx;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ien  <= 1'b0;
         r_txen <= 1'b0;
         r_div  <= 16'(DIV_RESET);
         r_ovf  <= 1'b0;
         r_irq  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_odd  <= 1'b0;
`endif
      end else begin
         if (WE && Addr == ADDR_CTRL) begin
            r_ien  <= DataI[CTRL_IEN];
            r_txen <= DataI[CTRL_TXEN];
`ifdef UART_TX_PARITY_EN
            r_odd  <= DataI[CTRL_ODD];
`endif
         end
         if (WE && Addr == ADDR_DIV)
            r_div <= (DataI[15:0] == 16'd0) ? 16'd1 : DataI[15:0];
         if (w_push && w_full && !w_pop)   r_ovf <= 1'b1;
         else if (WE && Addr == ADDR_STATUS) r_ovf <= 1'b0;
         r_irq <= r_ien && w_empty && !w_busy;
      end
   end

   always_comb begin
      DataO = '0;
      unique case (Addr)
         ADDR_STATUS: begin
            DataO[STAT_BUSY]  = w_busy;
            DataO[STAT_FULL]  = w_full;
            DataO[STAT_EMPTY] = w_empty;
            DataO[STAT_OVF]   = r_ovf;
         end
         ADDR_CTRL: begin
            DataO[CTRL_IEN]  = r_ien;
            DataO[CTRL_TXEN] = r_txen;
`ifdef UART_TX_PARITY_EN
            DataO[CTRL_ODD]  = r_odd;
`endif
         end
         ADDR_DIV: DataO[15:0] = r_div;
         default:  DataO = '0;
      endcase
   end

   assign IRQ = r_irq;
   assign TxD = r_txd;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register map, frame timing, FIFO overflow, IRQ and divisor edges.
`timescale 1ns/1ps
module tb_uart_tx_dev;
   import uart_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  Addr  = ADDR_STATUS;
   logic        WE    = 1'b0;
   logic [31:0] DataI = '0;
   logic [31:0] DataO;
   logic        IRQ;
   logic        TxD;

   int total = 0;
   int bad   = 0;
   bit g_chk_busy = 1'b0;
   bit g_chk_irq0 = 1'b0;

   uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(434)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .DataI (DataI),
      .DataO (DataO),
      .IRQ   (IRQ),
      .TxD   (TxD)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called just after a falling edge; the write is sampled on the next rising edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      Addr  = a;
      DataI = d;
      WE    = 1'b1;
      @(negedge clk);
      WE    = 1'b0;
      Addr  = ADDR_STATUS;
      DataI = '0;
   endtask

   task automatic rd(input logic [1:0] a);
      Addr = a;
      #1;
   endtask

   // mode 0: frame starts at next falling edge; 1: search for the start bit; 2: start bit already showing.
   task automatic expect_frame(input logic [7:0] b, input int div, input int mode, input string tag);
      logic [10:0] bits;
      int          nb;
      bit          found;
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
      nb   = 11;
`else
      bits = {1'b1, 1'b1, b, 1'b0};
      nb   = 10;
`endif
      if (mode == 1) begin
         found = 1'b0;
         for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (TxD === 1'b0) found = 1'b1;
         end
         total++;
         if (!found) begin
            bad++;
            $display("FAIL %s start: no start bit seen, wanted one within 200 cycles", tag);
            return;
         end
      end else if (mode == 0) begin
         @(negedge clk);
      end
      for (int k = 0; k < nb; k++) begin
         for (int c = 0; c < div; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            total++;
            if (TxD !== bits[k]) begin
               bad++;
               $display("FAIL %s bit%0d cyc%0d: TxD=%b want %b", tag, k, c, TxD, bits[k]);
            end
            if (g_chk_busy) begin
               total++;
               if (DataO[STAT_BUSY] !== 1'b1) begin
                  bad++;
                  $display("FAIL %s busy bit%0d: got %b want 1", tag, k, DataO[STAT_BUSY]);
               end
            end
            if (g_chk_irq0) begin
               total++;
               if (IRQ !== 1'b0) begin
                  bad++;
                  $display("FAIL %s irq bit%0d: got %b want 0", tag, k, IRQ);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (TxD !== 1'b1) begin bad++; $display("FAIL rst txd: got %b want 1", TxD); end
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL rst irq: got %b want 0", IRQ); end
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'h4) begin bad++; $display("FAIL rst status: got %h want 4", DataO); end
      rd(ADDR_DIV);
      total++; if (DataO !== 32'd434) begin bad++; $display("FAIL rst div: got %0d want 434", DataO); end
      Addr = ADDR_STATUS;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_write(ADDR_DIV, 32'd4);
      bus_write(ADDR_CTRL, 32'h2);
      bus_write(ADDR_TXDATA, 32'h00);
      repeat (3) @(negedge clk);
      total++; if (TxD !== 1'b0) begin bad++; $display("FAIL rst midframe start: got %b want 0", TxD); end
      #2 reset = 1'b0;
      #1;
      total++; if (TxD !== 1'b1) begin bad++; $display("FAIL rst abort txd: got %b want 1", TxD); end
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL rst abort irq: got %b want 0", IRQ); end
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'h4) begin bad++; $display("FAIL rst abort status: got %h want 4", DataO); end
      rd(ADDR_CTRL);
      total++; if (DataO !== 32'h0) begin bad++; $display("FAIL rst abort ctrl: got %h want 0", DataO); end
      rd(ADDR_DIV);
      total++; if (DataO !== 32'd434) begin bad++; $display("FAIL rst abort div: got %0d want 434", DataO); end
      Addr = ADDR_STATUS;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (TxD !== 1'b1) begin bad++; $display("FAIL rst after release txd: got %b want 1", TxD); end
   endtask

   task automatic test_single_byte();
      bus_write(ADDR_DIV, 32'd4);
      bus_write(ADDR_CTRL, 32'h2);
      bus_write(ADDR_TXDATA, 32'hA5);
      total++; if (TxD !== 1'b1) begin bad++; $display("FAIL single latency: TxD=%b want 1 before 2nd edge", TxD); end
      g_chk_busy = 1'b1;
      expect_frame(8'hA5, 4, 0, "single");
      g_chk_busy = 1'b0;
      @(negedge clk);
      total++; if (DataO[STAT_BUSY] !== 1'b0) begin bad++; $display("FAIL single busy after: got %b want 0", DataO[STAT_BUSY]); end
      total++; if (TxD !== 1'b1) begin bad++; $display("FAIL single idle txd: got %b want 1", TxD); end
   endtask

   task automatic test_overflow();
      logic [7:0] data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bus_write(ADDR_DIV, 32'd2);
      bus_write(ADDR_CTRL, 32'h0);
      for (int i = 0; i < 5; i++) bus_write(ADDR_TXDATA, {24'h0, data[i]});
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'hA) begin bad++; $display("FAIL ovf status: got %h want a", DataO); end
      bus_write(ADDR_STATUS, 32'h0);
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'h2) begin bad++; $display("FAIL ovf clear: got %h want 2", DataO); end
      bus_write(ADDR_CTRL, 32'h2);
      expect_frame(data[0], 2, 0, "ovf f0");
      for (int i = 1; i < 4; i++) expect_frame(data[i], 2, 0, "ovf bb");
      @(negedge clk);
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'h4) begin bad++; $display("FAIL ovf drained: got %h want 4", DataO); end
      repeat (10) @(negedge clk);
      total++; if (TxD !== 1'b1) begin bad++; $display("FAIL ovf dropped byte sent: TxD=%b want 1", TxD); end
   endtask

   task automatic test_irq();
      bus_write(ADDR_DIV, 32'd1);
      bus_write(ADDR_CTRL, 32'h3);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq early: got %b want 0", IRQ); end
      @(negedge clk);
      total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL irq rise: got %b want 1", IRQ); end
      bus_write(ADDR_TXDATA, 32'h55);
      total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL irq hold on write edge: got %b want 1", IRQ); end
      g_chk_irq0 = 1'b1;
      expect_frame(8'h55, 1, 0, "irq");
      g_chk_irq0 = 1'b0;
      @(negedge clk);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq stop end: got %b want 0", IRQ); end
      @(negedge clk);
      total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL irq after stop: got %b want 1", IRQ); end
      bus_write(ADDR_CTRL, 32'h2);
      @(negedge clk);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq ien clear: got %b want 0", IRQ); end
   endtask

   task automatic test_divisor();
      bus_write(ADDR_DIV, 32'd0);
      rd(ADDR_DIV);
      total++; if (DataO !== 32'd1) begin bad++; $display("FAIL div zero: got %0d want 1", DataO); end
      Addr = ADDR_STATUS;
      bus_write(ADDR_TXDATA, 32'h3C);
      g_chk_busy = 1'b1;
      expect_frame(8'h3C, 1, 0, "div1");
      g_chk_busy = 1'b0;
      @(negedge clk);
      total++; if (DataO !== 32'h4) begin bad++; $display("FAIL div1 end status: got %h want 4", DataO); end
      bus_write(ADDR_DIV, 32'd2);
      bus_write(ADDR_TXDATA, 32'hC3);
      fork
         begin
            expect_frame(8'hC3, 2, 1, "div old");
            expect_frame(8'h81, 8, 0, "div new");
         end
         begin
            bus_write(ADDR_TXDATA, 32'h81);
            repeat (3) @(negedge clk);
            bus_write(ADDR_DIV, 32'd8);
         end
      join
      rd(ADDR_DIV);
      total++; if (DataO !== 32'd8) begin bad++; $display("FAIL div readback: got %0d want 8", DataO); end
      Addr = ADDR_STATUS;
      @(negedge clk);
      total++; if (DataO !== 32'h4) begin bad++; $display("FAIL div end status: got %h want 4", DataO); end
   endtask

   task automatic test_full_pop();
      logic [7:0] data [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      bus_write(ADDR_DIV, 32'd1);
      bus_write(ADDR_CTRL, 32'h0);
      for (int i = 0; i < 4; i++) bus_write(ADDR_TXDATA, {24'h0, data[i]});
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'h2) begin bad++; $display("FAIL fullpop full: got %h want 2", DataO); end
      bus_write(ADDR_CTRL, 32'h2);
      bus_write(ADDR_TXDATA, {24'h0, data[4]});
      rd(ADDR_STATUS);
      total++; if (DataO !== 32'h3) begin bad++; $display("FAIL fullpop status: got %h want 3", DataO); end
      expect_frame(data[0], 1, 2, "fullpop f0");
      for (int i = 1; i < 5; i++) expect_frame(data[i], 1, 0, "fullpop bb");
      @(negedge clk);
      total++; if (DataO !== 32'h4) begin bad++; $display("FAIL fullpop end: got %h want 4", DataO); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_overflow();
      test_irq();
      test_divisor();
      test_full_pop();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
